// File: rtl/scm_burst_reader_if.sv
// Bundle of the three channels around the burst reader: command in,
// memory read port out, and the output word stream.
interface scm_burst_reader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  // command channel
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]  cmd_len_i;
  // memory read port (1-cycle registered read latency)
  logic                  mem_read_enable_o;
  logic [ADDR_WIDTH-1:0] mem_read_addr_o;
  logic [DATA_WIDTH-1:0] mem_read_data_i;
  // output stream
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_last_o;

  // The burst reader itself
  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, mem_read_data_i, out_ready_i,
    output cmd_ready_o, mem_read_enable_o, mem_read_addr_o,
           out_valid_o, out_data_o, out_last_o
  );

  // Whatever surrounds it: command source, memory, stream consumer
  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, mem_read_data_i, out_ready_i,
    input  cmd_ready_o, mem_read_enable_o, mem_read_addr_o,
           out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/scm_burst_reader.sv
// Burst read initiator: turns an (address, length) command into one memory
// read per cycle and streams the returned words through a 2-entry FIFO,
// flagging the final word of the burst.
module scm_burst_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst,
  scm_burst_reader_if.master bus,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];

  logic       cmd_ready;
  logic       cmd_fire;
  logic       out_valid;
  logic       pop;
  logic       push;
  logic       issue;
  logic       last_beat;
  logic [2:0] occupancy;

  // Handshake decode and read-issue decision. Occupancy counts words already
  // buffered plus the read whose data arrives next cycle, minus the word
  // leaving now; keeping it below 2 guarantees the FIFO can never overflow.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && !rst;
    cmd_fire  = bus.cmd_valid_i && cmd_ready;
    out_valid = (count_q != 2'd0);
    pop       = out_valid && bus.out_ready_i;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == ST_READ) && (remaining_q != '0) &&
                (occupancy < 3'd2) && !rst;
    last_beat = out_valid && ((beat_q + LEN_WIDTH'(1)) == len_q);
  end

  // FSM next-state and done pulse
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (bus.cmd_len_i != '0) begin
            state_d = ST_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (issue && (remaining_q == LEN_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && last_beat) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next-state: address walk, burst counters and FIFO pointers
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    beat_d      = beat_q;
    inflight_d  = issue;
    rd_ptr_d    = rd_ptr_q ^ pop;
    wr_ptr_d    = wr_ptr_q ^ push;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      beat_d = beat_q + LEN_WIDTH'(1);
    end
    if (issue) begin
      // natural wrap at the top of the address space
      addr_d      = addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - LEN_WIDTH'(1);
    end
    if (cmd_fire) begin
      addr_d      = bus.cmd_addr_i;
      remaining_d = bus.cmd_len_i;
      len_d       = bus.cmd_len_i;
      beat_d      = '0;
    end
  end

  // State and control registers; reset aborts any burst and drops in-flight data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // FIFO storage: capture memory data only in the cycle after an issued read
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= bus.mem_read_data_i;
    end
  end

  assign bus.cmd_ready_o       = cmd_ready;
  assign bus.mem_read_enable_o = issue;
  assign bus.mem_read_addr_o   = addr_q;
  assign bus.out_valid_o       = out_valid;
  assign bus.out_data_o        = fifo_q[rd_ptr_q];
  assign bus.out_last_o        = last_beat;
  assign busy_o                = (state_q != ST_IDLE);
  assign done_o                = done_q;

endmodule

// File: tb/tb_scm_burst_reader.sv
// Directed bench for scm_burst_reader: a behavioural 1-cycle-latency memory,
// a per-cycle recorder of DUT outputs, and one task per scenario.
module tb_scm_burst_reader;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;

  int errors = 0;
  int checks = 0;

  scm_burst_reader_if bus_if ();

  scm_burst_reader dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word per address
  function automatic logic [63:0] word_of(input logic [4:0] a);
    return {32'hCAFE_0000 | {27'h0, a}, ~{27'h0, a}};
  endfunction

  // Registered-read memory; garbage when not enabled so stray captures show up
  always @(posedge clk) begin
    if (bus_if.mem_read_enable_o)
      bus_if.mem_read_data_i <= word_of(bus_if.mem_read_addr_o);
    else
      bus_if.mem_read_data_i <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // Per-run recordings
  logic        h_en    [64];
  logic        h_valid [64];
  logic        h_done  [64];
  logic        h_busy  [64];
  logic        h_rdy   [64];
  logic [4:0]  en_addr   [$];
  logic [63:0] beat_data [$];
  logic        beat_last [$];
  int          beat_cyc  [$];
  int          done_cnt, done_cyc, busy_cnt, max_out, stall_viol, chain_cyc;
  logic        chain_rdy;

  // Drive one command at cycle 0 and record outputs for ncyc cycles.
  // mode 0: out_ready always 1; mode 1: out_ready high every third cycle.
  // Optional reset pulse at rst_at, optional follow-on command on done.
  task automatic run_burst(input logic [4:0] a, input logic [5:0] l, input int mode,
                           input int ncyc, input int rst_at, input bit chain,
                           input logic [4:0] a2, input logic [5:0] l2);
    int          issued     = 0;
    int          popped     = 0;
    bit          stall_prev = 1'b0;
    logic [63:0] stall_data = '0;
    bit          chained    = 1'b0;
    en_addr.delete(); beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; max_out = 0; stall_viol = 0;
    chain_cyc = -1; chain_rdy = 1'b0;
    for (int i = 0; i < 64; i++) begin
      h_en[i] = 1'b0; h_valid[i] = 1'b0; h_done[i] = 1'b0; h_busy[i] = 1'b0; h_rdy[i] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      bus_if.cmd_valid_i = (c == 0);
      if (c == 0) begin
        bus_if.cmd_addr_i = a;
        bus_if.cmd_len_i  = l;
      end
      rst = (c == rst_at);
      bus_if.out_ready_i = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      #1;
      h_en[c]    = bus_if.mem_read_enable_o;
      h_valid[c] = bus_if.out_valid_o;
      h_done[c]  = done;
      h_busy[c]  = busy;
      h_rdy[c]   = bus_if.cmd_ready_o;
      if (bus_if.mem_read_enable_o) begin
        en_addr.push_back(bus_if.mem_read_addr_o);
        issued++;
      end
      if (bus_if.out_valid_o && bus_if.out_ready_i) begin
        beat_data.push_back(bus_if.out_data_o);
        beat_last.push_back(bus_if.out_last_o);
        beat_cyc.push_back(c);
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (stall_prev && (!bus_if.out_valid_o || bus_if.out_data_o !== stall_data)) stall_viol++;
      stall_prev = bus_if.out_valid_o && !bus_if.out_ready_i && !rst;
      stall_data = bus_if.out_data_o;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) busy_cnt++;
      if (chain && !chained && done) begin
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_addr_i  = a2;
        bus_if.cmd_len_i   = l2;
        chained   = 1'b1;
        chain_cyc = c;
        chain_rdy = bus_if.cmd_ready_o;
      end
    end
    rst = 1'b0;
    $display("burst addr=%0d len=%0d enables=%0d beats=%0d done_pulses=%0d first_done=%0d",
             a, l, en_addr.size(), beat_data.size(), done_cnt, done_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.cmd_valid_i = 1'b0; bus_if.cmd_addr_i = '0; bus_if.cmd_len_i = '0;
    bus_if.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus_if.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready_during: got %0b expected 0", bus_if.cmd_ready_o); end
    @(posedge clk); #1; rst = 1'b0; #1;
    checks++; if (bus_if.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b expected 1", bus_if.cmd_ready_o); end
    checks++; if (bus_if.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus_if.out_valid_o); end
    checks++; if (bus_if.out_last_o !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b expected 0", bus_if.out_last_o); end
    checks++; if (bus_if.out_data_o !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", bus_if.out_data_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (bus_if.mem_read_enable_o !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %0b expected 0", bus_if.mem_read_enable_o); end
    checks++; if (bus_if.mem_read_addr_o !== 5'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", bus_if.mem_read_addr_o); end
  endtask

  task automatic test_basic();
    logic exp_en;
    run_burst(5'd4, 6'd3, 0, 10, -1, 1'b0, 5'd0, 6'd0);
    for (int c = 0; c < 10; c++) begin
      exp_en = (c >= 1) && (c <= 3);
      checks++; if (h_en[c] !== exp_en) begin errors++; $display("FAIL basic_enable cyc %0d: got %0b expected %0b", c, h_en[c], exp_en); end
    end
    checks++; if (en_addr.size() != 3) begin errors++; $display("FAIL basic_enable_count: got %0d expected 3", en_addr.size()); end
    for (int i = 0; i < en_addr.size() && i < 3; i++) begin
      checks++; if (en_addr[i] !== 5'(4 + i)) begin errors++; $display("FAIL basic_addr %0d: got %0d expected %0d", i, en_addr[i], 4 + i); end
    end
    checks++; if (beat_data.size() != 3) begin errors++; $display("FAIL basic_beat_count: got %0d expected 3", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 3; i++) begin
      checks++; if (beat_data[i] !== word_of(5'(4 + i))) begin errors++; $display("FAIL basic_data %0d: got %0h expected %0h", i, beat_data[i], word_of(5'(4 + i))); end
      checks++; if (beat_last[i] !== (i == 2)) begin errors++; $display("FAIL basic_last %0d: got %0b expected %0b", i, beat_last[i], (i == 2)); end
      checks++; if (beat_cyc[i] != 3 + i) begin errors++; $display("FAIL basic_beat_cycle %0d: got %0d expected %0d", i, beat_cyc[i], 3 + i); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 6", done_cyc); end
    checks++; if (h_rdy[6] !== 1'b1) begin errors++; $display("FAIL basic_ready_at_done: got %0b expected 1", h_rdy[6]); end
    checks++; if (h_rdy[3] !== 1'b0) begin errors++; $display("FAIL basic_ready_busy: got %0b expected 0", h_rdy[3]); end
    checks++; if (h_busy[5] !== 1'b1) begin errors++; $display("FAIL basic_busy_drain: got %0b expected 1", h_busy[5]); end
    checks++; if (h_busy[6] !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %0b expected 0", h_busy[6]); end
  endtask

  task automatic test_wrap();
    int ea[4] = '{30, 31, 0, 1};
    run_burst(5'd30, 6'd4, 0, 12, -1, 1'b0, 5'd0, 6'd0);
    checks++; if (en_addr.size() != 4) begin errors++; $display("FAIL wrap_enable_count: got %0d expected 4", en_addr.size()); end
    for (int i = 0; i < en_addr.size() && i < 4; i++) begin
      checks++; if (en_addr[i] !== 5'(ea[i])) begin errors++; $display("FAIL wrap_addr %0d: got %0d expected %0d", i, en_addr[i], ea[i]); end
    end
    checks++; if (beat_data.size() != 4) begin errors++; $display("FAIL wrap_beat_count: got %0d expected 4", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 4; i++) begin
      checks++; if (beat_data[i] !== word_of(5'(ea[i]))) begin errors++; $display("FAIL wrap_data %0d: got %0h expected %0h", i, beat_data[i], word_of(5'(ea[i]))); end
      checks++; if (beat_last[i] !== (i == 3)) begin errors++; $display("FAIL wrap_last %0d: got %0b expected %0b", i, beat_last[i], (i == 3)); end
    end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 7", done_cyc); end
  endtask

  task automatic test_backpressure();
    run_burst(5'd8, 6'd8, 1, 40, -1, 1'b0, 5'd0, 6'd0);
    checks++; if (en_addr.size() != 8) begin errors++; $display("FAIL bp_enable_count: got %0d expected 8", en_addr.size()); end
    for (int i = 0; i < en_addr.size() && i < 8; i++) begin
      checks++; if (en_addr[i] !== 5'(8 + i)) begin errors++; $display("FAIL bp_addr %0d: got %0d expected %0d", i, en_addr[i], 8 + i); end
    end
    checks++; if (beat_data.size() != 8) begin errors++; $display("FAIL bp_beat_count: got %0d expected 8", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 8; i++) begin
      checks++; if (beat_data[i] !== word_of(5'(8 + i))) begin errors++; $display("FAIL bp_data %0d: got %0h expected %0h", i, beat_data[i], word_of(5'(8 + i))); end
      checks++; if (beat_last[i] !== (i == 7)) begin errors++; $display("FAIL bp_last %0d: got %0b expected %0b", i, beat_last[i], (i == 7)); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stability: got %0d unstable cycles expected 0", stall_viol); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: got %0d expected at most 2", max_out); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != 25) begin errors++; $display("FAIL bp_done_cycle: got %0d expected 25", done_cyc); end
  endtask

  task automatic test_empty();
    run_burst(5'd5, 6'd0, 0, 6, -1, 1'b0, 5'd0, 6'd0);
    checks++; if (h_rdy[0] !== 1'b1) begin errors++; $display("FAIL empty_cmd_ready: got %0b expected 1", h_rdy[0]); end
    checks++; if (en_addr.size() != 0) begin errors++; $display("FAIL empty_enables: got %0d expected 0", en_addr.size()); end
    checks++; if (beat_data.size() != 0) begin errors++; $display("FAIL empty_beats: got %0d expected 0", beat_data.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL empty_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 1", done_cyc); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL empty_busy: got %0d busy cycles expected 0", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    run_burst(5'd0, 6'd16, 0, 12, 5, 1'b0, 5'd0, 6'd0);
    checks++; if (beat_data.size() < 2) begin errors++; $display("FAIL rstmid_beats_before: got %0d expected at least 2", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 2; i++) begin
      checks++; if (beat_data[i] !== word_of(5'(i))) begin errors++; $display("FAIL rstmid_data %0d: got %0h expected %0h", i, beat_data[i], word_of(5'(i))); end
    end
    checks++; if (h_rdy[5] !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst: got %0b expected 0", h_rdy[5]); end
    checks++; if (h_en[5] !== 1'b0) begin errors++; $display("FAIL rstmid_enable_in_rst: got %0b expected 0", h_en[5]); end
    checks++; if (h_valid[6] !== 1'b0) begin errors++; $display("FAIL rstmid_valid_after: got %0b expected 0", h_valid[6]); end
    checks++; if (h_rdy[6] !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %0b expected 1", h_rdy[6]); end
    checks++; if (h_valid[7] !== 1'b0) begin errors++; $display("FAIL rstmid_valid_flushed: got %0b expected 0", h_valid[7]); end
    checks++; if (h_busy[6] !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %0b expected 0", h_busy[6]); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    run_burst(5'd10, 6'd2, 0, 8, -1, 1'b0, 5'd0, 6'd0);
    checks++; if (beat_data.size() != 2) begin errors++; $display("FAIL rstmid_new_beats: got %0d expected 2", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 2; i++) begin
      checks++; if (beat_data[i] !== word_of(5'(10 + i))) begin errors++; $display("FAIL rstmid_new_data %0d: got %0h expected %0h", i, beat_data[i], word_of(5'(10 + i))); end
      checks++; if (beat_last[i] !== (i == 1)) begin errors++; $display("FAIL rstmid_new_last %0d: got %0b expected %0b", i, beat_last[i], (i == 1)); end
    end
    checks++; if (done_cyc != 5) begin errors++; $display("FAIL rstmid_new_done_cycle: got %0d expected 5", done_cyc); end
  endtask

  task automatic test_back_to_back();
    int   ea[5] = '{20, 21, 22, 2, 3};
    int   ec[5] = '{3, 4, 5, 9, 10};
    logic el[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_burst(5'd20, 6'd3, 0, 16, -1, 1'b1, 5'd2, 6'd2);
    checks++; if (chain_cyc != 6) begin errors++; $display("FAIL b2b_chain_cycle: got %0d expected 6", chain_cyc); end
    checks++; if (chain_rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done: got %0b expected 1", chain_rdy); end
    checks++; if (en_addr.size() != 5) begin errors++; $display("FAIL b2b_enable_count: got %0d expected 5", en_addr.size()); end
    for (int i = 0; i < en_addr.size() && i < 5; i++) begin
      checks++; if (en_addr[i] !== 5'(ea[i])) begin errors++; $display("FAIL b2b_addr %0d: got %0d expected %0d", i, en_addr[i], ea[i]); end
    end
    checks++; if (beat_data.size() != 5) begin errors++; $display("FAIL b2b_beat_count: got %0d expected 5", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 5; i++) begin
      checks++; if (beat_data[i] !== word_of(5'(ea[i]))) begin errors++; $display("FAIL b2b_data %0d: got %0h expected %0h", i, beat_data[i], word_of(5'(ea[i]))); end
      checks++; if (beat_last[i] !== el[i]) begin errors++; $display("FAIL b2b_last %0d: got %0b expected %0b", i, beat_last[i], el[i]); end
      checks++; if (beat_cyc[i] != ec[i]) begin errors++; $display("FAIL b2b_beat_cycle %0d: got %0d expected %0d", i, beat_cyc[i], ec[i]); end
    end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    checks++; if (h_done[11] !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %0b expected 1", h_done[11]); end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_addr_i  = '0;
    bus_if.cmd_len_i   = '0;
    bus_if.out_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
